// File: rtl/decoder_onehot_pipe.sv
// Registered binary-to-onehot decoder with a 2-entry output FIFO and valid/ready on both sides.
// Out-of-range indices decode to all-zeros with a per-beat err flag and a sticky status bit.
module decoder_onehot_pipe #(
  parameter int NUM_BITS     = 11,
  parameter int LOG_NUM_BITS = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i__valid,
  input  logic [LOG_NUM_BITS-1:0] i__encode,
  output logic                    o__ready,
  output logic                    o__valid,
  output logic [NUM_BITS-1:0]     o__onehot,
  output logic                    o__err,
  input  logic                    i__ready,
  output logic                    o__err_sticky,
  input  logic                    i__err_clear
);

  typedef struct packed {
    logic                err;
    logic [NUM_BITS-1:0] onehot;
  } entry_t;

  entry_t       dec;
  entry_t [1:0] buf_q, buf_d;
  logic   [1:0] cnt_q, cnt_d;
  logic         sticky_q, sticky_d;
  logic         push, pop, wptr;

  // Indices past NUM_BITS match no bit, so err falls out of the decode itself.
  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_BITS; i++)
      dec.onehot[i] = (i__encode == LOG_NUM_BITS'(i));
    dec.err = ~|dec.onehot;
  end

  assign o__ready      = (cnt_q != 2'd2);
  assign o__valid      = |cnt_q;
  assign o__onehot     = buf_q[0].onehot;
  assign o__err        = buf_q[0].err;
  assign o__err_sticky = sticky_q;

  assign push = i__valid & o__ready;
  assign pop  = o__valid & i__ready;
  // Slot for the new beat: slot 1 only when one entry stays resident.
  assign wptr = cnt_q[0] & ~pop;

  // Unused slots are kept zero so an empty buffer presents onehot=0, err=0.
  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    sticky_d = sticky_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = '0;
    end
    if (push) buf_d[wptr] = dec;
    if (i__err_clear)      sticky_d = 1'b0;
    if (push && dec.err)   sticky_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// Scoreboard bench: driver queues expected beats on acceptance, negedge monitor compares outputs.
module tb_decoder_onehot_pipe;
  localparam int NB = 11;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst;
  logic i__valid, i__ready, i__err_clear;
  logic [LB-1:0] i__encode;
  logic o__ready, o__valid, o__err, o__err_sticky;
  logic [NB-1:0] o__onehot;

  // Second build with a power-of-two width.
  logic v8, r8o, v8o, err8o, sticky8o;
  logic [2:0] e8;
  logic [7:0] oh8;

  always #5 clk = ~clk;

  decoder_onehot_pipe #(.NUM_BITS(NB)) dut (
    .clk(clk), .rst(rst), .i__valid(i__valid), .i__encode(i__encode),
    .o__ready(o__ready), .o__valid(o__valid), .o__onehot(o__onehot), .o__err(o__err),
    .i__ready(i__ready), .o__err_sticky(o__err_sticky), .i__err_clear(i__err_clear)
  );

  decoder_onehot_pipe #(.NUM_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .i__valid(v8), .i__encode(e8),
    .o__ready(r8o), .o__valid(v8o), .o__onehot(oh8), .o__err(err8o),
    .i__ready(1'b1), .o__err_sticky(sticky8o), .i__err_clear(1'b0)
  );

  typedef struct {
    logic [NB-1:0] oh;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   q8[$];
  int   total = 0, bad = 0, acc = 0, got8 = 0;
  logic m_sticky = 1'b0;
  logic mon_en = 1'b0;

  function automatic exp_t model(int idx);
    exp_t e;
    if (idx < NB) begin e.oh = NB'(1 << idx); e.err = 1'b0; end
    else          begin e.oh = '0;            e.err = 1'b1; end
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  // Expected state between edges: queue size is the buffer count.
  always @(negedge clk) if (mon_en) begin
    chk("valid", o__valid, exp_q.size() != 0);
    chk("ready", o__ready, exp_q.size() < 2);
    chk("sticky", o__err_sticky, m_sticky);
    if (exp_q.size() != 0) begin
      chk("onehot", o__onehot, exp_q[0].oh);
      chk("err", o__err, exp_q[0].err);
      chk("shape", ($countones(o__onehot) == 1 && !o__err) || (o__onehot == 0 && o__err), 1);
      if (o__valid && i__ready) void'(exp_q.pop_front());
    end else begin
      chk("idle_onehot", o__onehot, 0);
      chk("idle_err", o__err, 0);
    end
  end

  always @(negedge clk) if (mon_en) begin
    chk("v8", v8o, q8.size() != 0);
    if (v8o && q8.size() != 0) begin
      chk("oh8", oh8, 32'(1) << q8[0]);
      chk("err8", err8o, 0);
      void'(q8.pop_front());
      got8++;
    end
  end

  // One clock: record what transfers at the coming edge, then return just after it.
  task automatic cyc();
    @(negedge clk); #1;
    if (rst) begin
      exp_q.delete(); q8.delete(); m_sticky = 1'b0;
    end else begin
      if (i__valid && o__ready) begin
        exp_q.push_back(model(int'(i__encode)));
        acc++;
        if (int'(i__encode) >= NB) m_sticky = 1'b1;
        else if (i__err_clear)     m_sticky = 1'b0;
      end else if (i__err_clear) m_sticky = 1'b0;
      if (v8 && r8o) q8.push_back(int'(e8));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    i__valid = 1'b0; v8 = 1'b0;
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    rst = 1'b1; i__valid = 1'b0; i__encode = '0; i__ready = 1'b1; i__err_clear = 1'b0;
    v8 = 1'b0; e8 = '0;
    cyc(); mon_en = 1'b1; cyc();
    rst = 1'b0;
    chk("rst_valid", o__valid, 0);
    chk("rst_onehot", o__onehot, 0);
    chk("rst_sticky", o__err_sticky, 0);
    chk("rst_ready", o__ready, 1);

    // Full-rate stream on both builds.
    for (int k = 0; k < NB; k++) begin
      i__valid = 1'b1; i__encode = LB'(k);
      v8 = (k < 8); e8 = 3'(k);
      cyc();
    end
    idle(3);
    chk("n8_beats", got8, 8);

    // Backpressure: two beats held, head stable.
    i__ready = 1'b0;
    i__valid = 1'b1; i__encode = 4'd3; cyc();
    i__encode = 4'd7; cyc();
    idle(3);
    chk("full_head", o__onehot, 11'h008);
    i__ready = 1'b1;
    idle(3);

    // Out-of-range beats and the sticky flag.
    i__valid = 1'b1; i__encode = 4'd12; cyc();
    i__encode = 4'd15; cyc();
    idle(2);
    chk("sticky_set", o__err_sticky, 1);
    i__err_clear = 1'b1; cyc(); i__err_clear = 1'b0;
    chk("sticky_clr", o__err_sticky, 0);
    i__valid = 1'b1; i__encode = 4'd12; i__err_clear = 1'b1; cyc();
    i__err_clear = 1'b0;
    chk("sticky_win", o__err_sticky, 1);
    idle(2);

    // Reset with a full buffer discards both beats.
    i__ready = 1'b0;
    i__valid = 1'b1; i__encode = 4'd13; cyc();
    i__encode = 4'd2; cyc();
    i__valid = 1'b0;
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mid_rst_valid", o__valid, 0);
    chk("mid_rst_onehot", o__onehot, 0);
    chk("mid_rst_sticky", o__err_sticky, 0);
    chk("mid_rst_ready", o__ready, 1);
    i__ready = 1'b1;
    idle(3);

    // Random traffic.
    acc = 0;
    for (int c = 0; c < 60000 && acc < 10000; c++) begin
      i__valid     = ($urandom_range(0, 9) < 7);
      i__encode    = LB'($urandom_range(0, 15));
      i__ready     = ($urandom_range(0, 9) < 6);
      i__err_clear = ($urandom_range(0, 15) == 0);
      cyc();
    end
    chk("rand_beats", acc >= 10000, 1);
    i__err_clear = 1'b0; i__ready = 1'b1;
    idle(4);
    chk("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
